// File: rtl/dmem_responder_if.sv
// Request/response channel between the pipeline MEM stage (master) and the
// multi-cycle data-memory responder (slave). The stall line travels with the
// channel because the pipeline consumes it alongside the handshake.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        stall;

  // MEM stage side: issues requests, observes completion and stall
  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  stall
  );

  // Responder side
  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder. Accepts one load/store at a time over a
// valid/ready channel, answers with a one-cycle resp_valid pulse and drives
// the pipeline stall. A host load port writes the array directly while idle.
//
// Timing: a request presented in cycle 0 is answered in cycle LATENCY-1,
// never earlier than cycle 1. LATENCY of 1 or 2 therefore goes straight from
// IDLE to RESP; larger values spend LATENCY-2 cycles in WAIT.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus,
  input  logic             ld_en_i,
  input  logic [15:0]      ld_addr_i,
  input  logic [15:0]      ld_data_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Go directly from IDLE to RESP when the latency leaves no WAIT cycle.
  localparam bit         DIRECT_RESP = (LATENCY <= 2);
  // Number of WAIT cycles loaded into the counter at accept.
  localparam logic [3:0] WAIT_LOAD   = (LATENCY > 2) ? 4'(LATENCY - 2) : 4'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    we_q;
  logic [DEPTH_LOG2-1:0]   addr_q;
  logic [15:0]             wdata_q;
  logic                    resp_valid_q;
  // Set when the last completed request was a load, so resp_rdata shows the
  // read register; cleared by reset and by stores so resp_rdata reads 0.
  logic                    rd_live_q;

  // Storage and its registered read port (no reset: contents survive reset).
  logic [15:0]             mem_q [DEPTH];
  logic [15:0]             rd_data_q;

  logic                    req_ready;
  logic                    accept;
  logic                    enter_resp;
  logic                    host_wr;
  logic                    access_we;
  logic [DEPTH_LOG2-1:0]   access_addr;
  logic [15:0]             access_wdata;
  logic                    mem_we;
  logic                    mem_re;
  logic [DEPTH_LOG2-1:0]   mem_waddr;
  logic [15:0]             mem_wdata;

  // Upper address bits are deliberately ignored (addresses alias modulo DEPTH).
  generate
    if (DEPTH_LOG2 < 16) begin : g_alias
      logic unused_addr_bits;
      assign unused_addr_bits = ^{ld_addr_i[15:DEPTH_LOG2], bus.req_addr[15:DEPTH_LOG2]};
    end
  endgenerate

  // Handshake, stall and the shared memory-port steering.
  always_comb begin
    req_ready    = (state_q == IDLE) && !ld_en_i;
    accept       = bus.req_valid && req_ready;
    host_wr      = ld_en_i && (state_q == IDLE);

    // In IDLE the access comes straight from the bus (only used when the
    // latency is short enough to enter RESP on the accept edge); otherwise
    // it comes from the fields latched at accept.
    access_we    = we_q;
    access_addr  = addr_q;
    access_wdata = wdata_q;
    if (state_q == IDLE) begin
      access_we    = bus.req_we;
      access_addr  = bus.req_addr[DEPTH_LOG2-1:0];
      access_wdata = bus.req_wdata;
    end

    enter_resp = 1'b0;
    if ((state_q == IDLE) && accept && DIRECT_RESP) begin
      enter_resp = 1'b1;
    end else if ((state_q == WAIT) && (cnt_q == 4'd1)) begin
      enter_resp = 1'b1;
    end

    // Host writes only happen in IDLE without an accept, store commits only
    // on the edge entering RESP, so the two never collide on the write port.
    mem_we    = host_wr || (enter_resp && access_we);
    mem_re    = enter_resp && !access_we;
    mem_waddr = access_addr;
    mem_wdata = access_wdata;
    if (host_wr) begin
      mem_waddr = ld_addr_i[DEPTH_LOG2-1:0];
      mem_wdata = ld_data_i;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rd_live_q ? rd_data_q : 16'h0000;
  assign bus.stall      = bus.req_valid && !resp_valid_q;

  // Request sequencing: IDLE -> (WAIT) -> RESP -> IDLE, one request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 16'h0000;
      resp_valid_q <= 1'b0;
      rd_live_q    <= 1'b0;
    end else begin
      if (enter_resp) begin
        rd_live_q <= !access_we;
      end
      case (state_q)
        IDLE: begin
          resp_valid_q <= 1'b0;
          if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr[DEPTH_LOG2-1:0];
            wdata_q <= bus.req_wdata;
            if (DIRECT_RESP) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            cnt_q        <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          cnt_q        <= 4'd0;
        end
      endcase
    end
  end

  // Data array write port and registered read port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
    if (mem_re) begin
      rd_data_q <= mem_q[access_addr];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=4 instance (A) and one
// LATENCY=1 instance (B) sharing clock and reset.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        ld_en_a, ld_en_b;
  logic [15:0] ld_addr_a, ld_data_a, ld_addr_b, ld_data_b;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_a),
    .ld_en_i   (ld_en_a),
    .ld_addr_i (ld_addr_a),
    .ld_data_i (ld_data_a)
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_b),
    .ld_en_i   (ld_en_b),
    .ld_addr_i (ld_addr_b),
    .ld_data_i (ld_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Host-port write into instance A (caller guarantees A is idle)
  task automatic host_write_a(input logic [15:0] addr, input logic [15:0] data);
    @(posedge clk); #1;
    ld_en_a = 1'b1; ld_addr_a = addr; ld_data_a = data;
    @(posedge clk); #1;
    ld_en_a = 1'b0;
    $display("txn A host  addr=%h data=%h", addr, data);
  endtask

  // Issue one request on A, return data and the cycle index of resp_valid
  task automatic run_req_a(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           output logic [15:0] rdata, output int lat);
    @(posedge clk); #1;
    bus_a.req_valid = 1'b1; bus_a.req_we = we; bus_a.req_addr = addr; bus_a.req_wdata = wdata;
    lat = -1; rdata = 16'h0000;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      if (bus_a.resp_valid === 1'b1) begin
        lat = c; rdata = bus_a.resp_rdata;
      end
      @(posedge clk); #1;
      if (lat >= 0) bus_a.req_valid = 1'b0;
    end
    if (lat < 0) begin
      bus_a.req_valid = 1'b0;
      n_checks++; n_fail++;
      $display("FAIL run_req_timeout: got no resp_valid, want one within 40 cycles (addr=%h)", addr);
    end
    $display("txn A %s addr=%h wdata=%h rdata=%h cycle=%0d", we ? "store" : "load ", addr, wdata, rdata, lat);
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (bus_a.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus_a.req_ready); end
    n_checks++; if (bus_a.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", bus_a.resp_valid); end
    n_checks++; if (bus_a.resp_rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata: got %h want 0000", bus_a.resp_rdata); end
    n_checks++; if (bus_a.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall_low: got %b want 0", bus_a.stall); end
    n_checks++; if (bus_b.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_resp_valid: got %b want 0", bus_b.resp_valid); end
    bus_a.req_valid = 1'b1;
    #1;
    n_checks++; if (bus_a.stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall_follow: got %b want 1", bus_a.stall); end
    bus_a.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn reset released");
  endtask

  // Host write then load, cycle-exact checks on every output
  task automatic test_host_then_load();
    logic exp_stall, exp_resp, exp_ready;
    host_write_a(16'h0005, 16'hBEEF);
    @(posedge clk); #1;
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 16'h0005; bus_a.req_wdata = 16'h0000;
    for (int c = 0; c <= 4; c++) begin
      if (c == 4) bus_a.req_valid = 1'b0;
      exp_stall = (c < 3);
      exp_resp  = (c == 3);
      exp_ready = (c == 0) || (c == 4);
      @(negedge clk);
      n_checks++; if (bus_a.stall !== exp_stall) begin n_fail++; $display("FAIL hl_stall c%0d: got %b want %b", c, bus_a.stall, exp_stall); end
      n_checks++; if (bus_a.resp_valid !== exp_resp) begin n_fail++; $display("FAIL hl_resp_valid c%0d: got %b want %b", c, bus_a.resp_valid, exp_resp); end
      n_checks++; if (bus_a.req_ready !== exp_ready) begin n_fail++; $display("FAIL hl_ready c%0d: got %b want %b", c, bus_a.req_ready, exp_ready); end
      if (c == 3) begin
        n_checks++; if (bus_a.resp_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL hl_rdata: got %h want BEEF", bus_a.resp_rdata); end
      end
      if (c < 4) begin @(posedge clk); #1; end
    end
    $display("txn A load  addr=0005 expected BEEF in cycle 3");
  endtask

  task automatic test_store_load();
    logic [15:0] rd;
    int          lat;
    run_req_a(1'b1, 16'h0010, 16'h1234, rd, lat);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL st_rdata: got %h want 0000", rd); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL st_latency: got %0d want 3", lat); end
    run_req_a(1'b0, 16'h0010, 16'h0000, rd, lat);
    n_checks++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL ld_rdata: got %h want 1234", rd); end
    run_req_a(1'b0, 16'h0410, 16'h0000, rd, lat);
    n_checks++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL alias_rdata: got %h want 1234", rd); end
  endtask

  // Reset during WAIT of a store: store abandoned, outputs cleared at once
  task automatic test_reset_mid();
    logic [15:0] rd;
    int          lat;
    host_write_a(16'h0003, 16'h5555);
    @(posedge clk); #1;
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_addr = 16'h0003; bus_a.req_wdata = 16'hAAAA;
    @(posedge clk); #2;
    n_checks++; if (bus_a.req_ready !== 1'b0) begin n_fail++; $display("FAIL rm_busy_ready: got %b want 0", bus_a.req_ready); end
    n_checks++; if (bus_a.resp_rdata !== 16'h1234) begin n_fail++; $display("FAIL rm_held_rdata: got %h want 1234", bus_a.resp_rdata); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus_a.req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b want 1", bus_a.req_ready); end
    n_checks++; if (bus_a.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_resp_valid: got %b want 0", bus_a.resp_valid); end
    n_checks++; if (bus_a.resp_rdata !== 16'h0000) begin n_fail++; $display("FAIL rm_rdata: got %h want 0000", bus_a.resp_rdata); end
    n_checks++; if (bus_a.stall !== 1'b1) begin n_fail++; $display("FAIL rm_stall: got %b want 1", bus_a.stall); end
    bus_a.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn A reset during store WAIT");
    run_req_a(1'b0, 16'h0003, 16'h0000, rd, lat);
    n_checks++; if (rd !== 16'h5555) begin n_fail++; $display("FAIL rm_after_load: got %h want 5555", rd); end
  endtask

  task automatic test_back_to_back();
    int   pulses = 0;
    logic exp_resp, exp_ready, exp_stall;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 16'h0005; bus_a.req_wdata = 16'h0000;
    for (int c = 0; c < 12; c++) begin
      exp_resp  = ((c % 4) == 3);
      exp_ready = ((c % 4) == 0);
      exp_stall = !exp_resp;
      @(negedge clk);
      n_checks++; if (bus_a.resp_valid !== exp_resp) begin n_fail++; $display("FAIL b2b_resp_valid c%0d: got %b want %b", c, bus_a.resp_valid, exp_resp); end
      n_checks++; if (bus_a.req_ready !== exp_ready) begin n_fail++; $display("FAIL b2b_ready c%0d: got %b want %b", c, bus_a.req_ready, exp_ready); end
      n_checks++; if (bus_a.stall !== exp_stall) begin n_fail++; $display("FAIL b2b_stall c%0d: got %b want %b", c, bus_a.stall, exp_stall); end
      if (bus_a.resp_valid === 1'b1) begin
        pulses++;
        n_checks++; if (bus_a.resp_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_rdata c%0d: got %h want BEEF", c, bus_a.resp_rdata); end
        $display("txn A load  addr=0005 rdata=%h cycle=%0d (back-to-back)", bus_a.resp_rdata, c);
      end
      @(posedge clk); #1;
    end
    bus_a.req_valid = 1'b0;
    n_checks++; if (pulses !== 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
  endtask

  task automatic test_latency1();
    logic exp_stall, exp_resp, exp_ready;
    @(posedge clk); #1;
    ld_en_b = 1'b1; ld_addr_b = 16'h0007; ld_data_b = 16'hC0DE;
    @(posedge clk); #1;
    ld_en_b = 1'b0;
    bus_b.req_valid = 1'b1; bus_b.req_we = 1'b0; bus_b.req_addr = 16'h0007; bus_b.req_wdata = 16'h0000;
    for (int c = 0; c <= 2; c++) begin
      if (c == 2) bus_b.req_valid = 1'b0;
      exp_stall = (c == 0);
      exp_resp  = (c == 1);
      exp_ready = (c != 1);
      @(negedge clk);
      n_checks++; if (bus_b.stall !== exp_stall) begin n_fail++; $display("FAIL l1_stall c%0d: got %b want %b", c, bus_b.stall, exp_stall); end
      n_checks++; if (bus_b.resp_valid !== exp_resp) begin n_fail++; $display("FAIL l1_resp_valid c%0d: got %b want %b", c, bus_b.resp_valid, exp_resp); end
      n_checks++; if (bus_b.req_ready !== exp_ready) begin n_fail++; $display("FAIL l1_ready c%0d: got %b want %b", c, bus_b.req_ready, exp_ready); end
      if (c == 1) begin
        n_checks++; if (bus_b.resp_rdata !== 16'hC0DE) begin n_fail++; $display("FAIL l1_rdata: got %h want C0DE", bus_b.resp_rdata); end
      end
      if (c < 2) begin @(posedge clk); #1; end
    end
    $display("txn B load  addr=0007 expected C0DE in cycle 1");
  endtask

  task automatic test_host_contention();
    logic [15:0] rd;
    int          lat;
    logic        exp_ready, exp_resp, exp_stall;
    // Host write attempted while busy must be dropped
    host_write_a(16'h0009, 16'h1111);
    @(posedge clk); #1;
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 16'h0005; bus_a.req_wdata = 16'h0000;
    for (int c = 0; c <= 4; c++) begin
      if (c == 1) begin ld_en_a = 1'b1; ld_addr_a = 16'h0009; ld_data_a = 16'h2222; end
      if (c == 3) ld_en_a = 1'b0;
      if (c == 4) bus_a.req_valid = 1'b0;
      @(negedge clk);
      if (c == 3) begin
        n_checks++; if (bus_a.resp_valid !== 1'b1) begin n_fail++; $display("FAIL hc_busy_resp: got %b want 1", bus_a.resp_valid); end
      end
      if (c < 4) begin @(posedge clk); #1; end
    end
    $display("txn A host  addr=0009 data=2222 issued while busy");
    run_req_a(1'b0, 16'h0009, 16'h0000, rd, lat);
    n_checks++; if (rd !== 16'h1111) begin n_fail++; $display("FAIL hc_ignored_write: got %h want 1111", rd); end

    // Host write and request together in IDLE: write wins, request waits
    @(posedge clk); #1;
    ld_en_a = 1'b1; ld_addr_a = 16'h0020; ld_data_a = 16'h7777;
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 16'h0020; bus_a.req_wdata = 16'h0000;
    for (int c = 0; c <= 4; c++) begin
      if (c == 1) ld_en_a = 1'b0;
      exp_ready = (c == 1);
      exp_resp  = (c == 4);
      exp_stall = (c != 4);
      @(negedge clk);
      n_checks++; if (bus_a.req_ready !== exp_ready) begin n_fail++; $display("FAIL hc_ready c%0d: got %b want %b", c, bus_a.req_ready, exp_ready); end
      n_checks++; if (bus_a.resp_valid !== exp_resp) begin n_fail++; $display("FAIL hc_resp_valid c%0d: got %b want %b", c, bus_a.resp_valid, exp_resp); end
      n_checks++; if (bus_a.stall !== exp_stall) begin n_fail++; $display("FAIL hc_stall c%0d: got %b want %b", c, bus_a.stall, exp_stall); end
      if (c == 4) begin
        n_checks++; if (bus_a.resp_rdata !== 16'h7777) begin n_fail++; $display("FAIL hc_rdata: got %h want 7777", bus_a.resp_rdata); end
      end
      @(posedge clk); #1;
    end
    bus_a.req_valid = 1'b0;
    $display("txn A host+load addr=0020 expected 7777 in cycle 4");
  endtask

  initial begin
    rst_n = 1'b0;
    ld_en_a = 1'b0; ld_addr_a = 16'h0000; ld_data_a = 16'h0000;
    ld_en_b = 1'b0; ld_addr_b = 16'h0000; ld_data_b = 16'h0000;
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = 16'h0000; bus_a.req_wdata = 16'h0000;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = 16'h0000; bus_b.req_wdata = 16'h0000;
    test_reset();
    test_host_then_load();
    test_store_load();
    test_reset_mid();
    test_back_to_back();
    test_latency1();
    test_host_contention();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
